// File: rtl/dcache_wb_ctrl_if.sv
// Core load/store port and word-serial memory port of the MEM-stage data cache.
interface dcache_wb_ctrl_if;
  logic        rd_req;
  logic [3:0]  wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  modport slave (
    input  rd_req, wr_req, addr, wr_data, mem_rdata, mem_ack,
    output rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output rd_req, wr_req, addr, wr_data, mem_rdata, mem_ack,
    input  rd_data, miss, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_wb_ctrl.sv
// Direct-mapped write-back / write-allocate data cache for the MEM stage.
// Hits answer combinationally; misses run a word-serial write-back then refill.
module dcache_wb_ctrl #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 2,
  parameter int TAG_ADDR_LEN  = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
  input logic             clk,
  input logic             rst,
  dcache_wb_ctrl_if.slave bus
);
  // state | meaning
  // IDLE  | serving hits, detecting misses
  // WB    | writing the dirty victim line back, one word per ack
  // FILL  | reading the requested line, one word per ack
  // DONE  | line installed; the access hits on the next cycle
  typedef enum logic [1:0] {IDLE, WB, FILL, DONE} state_t;

  localparam int NUM_SETS  = 1 << SET_ADDR_LEN;
  localparam int NUM_WORDS = 1 << (SET_ADDR_LEN + LINE_ADDR_LEN);
  localparam logic [LINE_ADDR_LEN-1:0] CNT_LAST = '1;
  localparam logic [LINE_ADDR_LEN-1:0] CNT_ZERO = '0;

  state_t                    state_q, state_d;
  logic [LINE_ADDR_LEN-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [NUM_SETS-1:0]       valid_q, valid_d, dirty_q, dirty_d;
  logic [TAG_ADDR_LEN-1:0]   tag_q [NUM_SETS];
  logic [TAG_ADDR_LEN-1:0]   tag_d [NUM_SETS];
  logic [31:0]               data_q [NUM_WORDS];
  logic [31:0]               data_d [NUM_WORDS];
  logic [TAG_ADDR_LEN-1:0]   req_tag_q, req_tag_d;
  logic [SET_ADDR_LEN-1:0]   req_set_q, req_set_d;
  logic                      mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0]               mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [31:0]               hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [LINE_ADDR_LEN-1:0]  a_off;
  logic [SET_ADDR_LEN-1:0]   a_set;
  logic [TAG_ADDR_LEN-1:0]   a_tag;
  logic                      store, access, hit;
  logic                      unused_addr_lsb;

  assign a_off   = bus.addr[LINE_ADDR_LEN+1:2];
  assign a_set   = bus.addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign a_tag   = bus.addr[31:LINE_ADDR_LEN+SET_ADDR_LEN+2];
  assign unused_addr_lsb = ^bus.addr[1:0];
  assign store   = |bus.wr_req;
  assign access  = bus.rd_req | store;
  assign hit     = rst & access & (state_q == IDLE) & valid_q[a_set] & (tag_q[a_set] == a_tag);
  assign cnt_inc = cnt_q + 1'b1;

  assign bus.rd_data   = hit ? data_q[{a_set, a_off}] : 32'd0;
  assign bus.miss      = rst & access & ~hit;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    data_d      = data_q;
    req_tag_d   = req_tag_q;
    req_set_d   = req_set_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
          if (store) begin
            for (int b = 0; b < 4; b++) begin
              if (bus.wr_req[b]) data_d[{a_set, a_off}][8*b +: 8] = bus.wr_data[8*b +: 8];
            end
            dirty_d[a_set] = 1'b1;
          end
        end else if (access) begin
          // Request is latched so a withdrawn access still completes as a normal fill.
          miss_cnt_d = miss_cnt_q + 32'd1;
          req_tag_d  = a_tag;
          req_set_d  = a_set;
          cnt_d      = CNT_ZERO;
          mem_req_d  = 1'b1;
          if (valid_q[a_set] & dirty_q[a_set]) begin
            state_d     = WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[a_set], a_set, CNT_ZERO, 2'b00};
            mem_wdata_d = data_q[{a_set, CNT_ZERO}];
          end else begin
            state_d        = FILL;
            valid_d[a_set] = 1'b0;
            mem_we_d       = 1'b0;
            mem_addr_d     = {a_tag, a_set, CNT_ZERO, 2'b00};
            mem_wdata_d    = 32'd0;
          end
        end
      end
      WB: begin
        if (bus.mem_ack) begin
          if (cnt_q == CNT_LAST) begin
            state_d            = FILL;
            cnt_d              = CNT_ZERO;
            valid_d[req_set_q] = 1'b0;
            mem_we_d           = 1'b0;
            mem_addr_d         = {req_tag_q, req_set_q, CNT_ZERO, 2'b00};
            mem_wdata_d        = 32'd0;
          end else begin
            cnt_d       = cnt_inc;
            mem_addr_d  = {tag_q[req_set_q], req_set_q, cnt_inc, 2'b00};
            mem_wdata_d = data_q[{req_set_q, cnt_inc}];
          end
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          data_d[{req_set_q, cnt_q}] = bus.mem_rdata;
          if (cnt_q == CNT_LAST) begin
            state_d            = DONE;
            cnt_d              = CNT_ZERO;
            tag_d[req_set_q]   = req_tag_q;
            valid_d[req_set_q] = 1'b1;
            dirty_d[req_set_q] = 1'b0;
            mem_req_d          = 1'b0;
            mem_we_d           = 1'b0;
          end else begin
            cnt_d      = cnt_inc;
            mem_addr_d = {req_tag_q, req_set_q, cnt_inc, 2'b00};
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= '0;
      dirty_q     <= '0;
      req_tag_q   <= '0;
      req_set_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      req_tag_q   <= req_tag_d;
      req_set_q   <= req_set_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Bench for dcache_wb_ctrl: directed scenarios plus random traffic against a
// line-level cache/memory model with a randomly slow memory responder.
module tb_dcache_wb_ctrl;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk;
  logic rst;
  dcache_wb_ctrl_if bus_if ();

  dcache_wb_ctrl #(.LINE_ADDR_LEN(3), .SET_ADDR_LEN(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model of cache contents and main memory (a word at address A holds A until written).
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] m_line [4][8];
  logic [24:0] m_tag [4];
  bit   [3:0]  m_valid, m_dirty;
  logic [31:0] m_hit_cnt, m_miss_cnt;
  int          phase;
  logic [1:0]  p_set;
  logic [24:0] p_tag;
  txn_t        exp_q[$];
  txn_t        txn_log[$];
  int          lat_cnt, cur_lat;
  int          lat_mode, fixed_lat;
  int          hits_seen, miss_cycles, fill_acks;
  logic [31:0] last_hit_data;
  int          mc0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic int pick_lat();
    if (lat_mode != 0) return int'($urandom_range(5, 1));
    return fixed_lat;
  endfunction

  task automatic step();
    logic        acc;
    logic [1:0]  s;
    logic [2:0]  o;
    logic [24:0] t;
    txn_t        tx;
    bus_if.mem_ack   = 1'b0;
    bus_if.mem_rdata = $urandom();
    if (bus_if.miss === 1'b1) miss_cycles++;
    if (rst !== 1'b1) begin
      chk("rst_miss", 32'(bus_if.miss), 32'd0);
      chk("rst_rd_data", bus_if.rd_data, 32'd0);
      chk("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
      chk("rst_hit_cnt", bus_if.hit_cnt, 32'd0);
      chk("rst_miss_cnt", bus_if.miss_cnt, 32'd0);
      m_valid = '0; m_dirty = '0; m_hit_cnt = '0; m_miss_cnt = '0;
      phase = 0; lat_cnt = 0; fill_acks = 0;
      exp_q.delete(); txn_log.delete();
      return;
    end
    chk("hit_cnt", bus_if.hit_cnt, m_hit_cnt);
    chk("miss_cnt", bus_if.miss_cnt, m_miss_cnt);
    acc = bus_if.rd_req | (|bus_if.wr_req);
    s = bus_if.addr[6:5];
    o = bus_if.addr[4:2];
    t = bus_if.addr[31:7];
    if (phase == 0) begin
      chk("idle_mem_req", 32'(bus_if.mem_req), 32'd0);
      if (acc && m_valid[s] && m_tag[s] == t) begin
        chk("hit_miss", 32'(bus_if.miss), 32'd0);
        chk("hit_rd_data", bus_if.rd_data, m_line[s][o]);
        last_hit_data = m_line[s][o];
        m_hit_cnt++;
        if (|bus_if.wr_req) begin
          m_line[s][o] = merge(m_line[s][o], bus_if.wr_data, bus_if.wr_req);
          m_dirty[s] = 1'b1;
        end
        hits_seen++;
      end else if (acc) begin
        chk("miss_flag", 32'(bus_if.miss), 32'd1);
        chk("miss_rd_data", bus_if.rd_data, 32'd0);
        m_miss_cnt++;
        txn_log.delete(); exp_q.delete(); fill_acks = 0;
        if (m_valid[s] && m_dirty[s]) begin
          for (int i = 0; i < 8; i++) begin
            tx.we = 1'b1; tx.addr = {m_tag[s], s, 3'(i), 2'b00}; tx.data = m_line[s][i];
            exp_q.push_back(tx);
          end
        end
        for (int i = 0; i < 8; i++) begin
          tx.we = 1'b0; tx.addr = {t, s, 3'(i), 2'b00}; tx.data = 32'd0;
          exp_q.push_back(tx);
        end
        p_set = s; p_tag = t; m_valid[s] = 1'b0; m_dirty[s] = 1'b0;
        phase = 1; lat_cnt = 0; cur_lat = pick_lat();
      end else begin
        chk("noacc_miss", 32'(bus_if.miss), 32'd0);
        chk("noacc_rd_data", bus_if.rd_data, 32'd0);
      end
    end else if (phase == 1) begin
      chk("busy_miss", 32'(bus_if.miss), 32'(acc));
      chk("busy_rd_data", bus_if.rd_data, 32'd0);
      chk("busy_mem_req", 32'(bus_if.mem_req), 32'd1);
      chk("mem_addr", bus_if.mem_addr, exp_q[0].addr);
      chk("mem_we", 32'(bus_if.mem_we), 32'(exp_q[0].we));
      if (exp_q[0].we) chk("mem_wdata", bus_if.mem_wdata, exp_q[0].data);
      lat_cnt++;
      if (lat_cnt >= cur_lat) begin
        bus_if.mem_ack = 1'b1;
        tx = exp_q.pop_front();
        if (tx.we) mem_arr[tx.addr] = tx.data;
        else begin
          tx.data = mem_rd(tx.addr);
          bus_if.mem_rdata = tx.data;
          m_line[p_set][tx.addr[4:2]] = tx.data;
          fill_acks++;
        end
        txn_log.push_back(tx);
        lat_cnt = 0;
        cur_lat = pick_lat();
        if (exp_q.size() == 0) phase = 2;
      end
    end else begin
      chk("done_mem_req", 32'(bus_if.mem_req), 32'd0);
      chk("done_miss", 32'(bus_if.miss), 32'(acc));
      chk("done_rd_data", bus_if.rd_data, 32'd0);
      m_valid[p_set] = 1'b1; m_tag[p_set] = p_tag; m_dirty[p_set] = 1'b0;
      phase = 0;
    end
  endtask

  initial begin
    bus_if.mem_ack = 1'b0;
    bus_if.mem_rdata = '0;
    forever begin
      @(negedge clk);
      step();
    end
  end

  task automatic wait_hit(input int h0);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (hits_seen != h0) break;
    end
    #2;
    bus_if.rd_req = 1'b0;
    bus_if.wr_req = 4'b0;
    chk("access_done", 32'(hits_seen - h0), 32'd1);
  endtask

  task automatic start_access(input logic rd, input logic [3:0] be, input logic [31:0] a,
                              input logic [31:0] d, output int h0);
    @(posedge clk);
    #2;
    bus_if.rd_req = rd; bus_if.wr_req = be; bus_if.addr = a; bus_if.wr_data = d;
    h0 = hits_seen;
    mc0 = miss_cycles;
  endtask

  task automatic do_access(input logic rd, input logic [3:0] be, input logic [31:0] a,
                           input logic [31:0] d);
    int h0;
    start_access(rd, be, a, d, h0);
    wait_hit(h0);
  endtask

  initial begin
    int h0;
    rst = 1'b0;
    bus_if.rd_req = 1'b1; bus_if.wr_req = 4'b0; bus_if.addr = 32'h14; bus_if.wr_data = '0;
    lat_mode = 0; fixed_lat = 2;
    hits_seen = 0; miss_cycles = 0; fill_acks = 0; phase = 0;
    m_hit_cnt = '0; m_miss_cnt = '0; m_valid = '0; m_dirty = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_miss", 32'(bus_if.miss), 32'd0);
    chk("reset_rd_data", bus_if.rd_data, 32'd0);
    chk("reset_mem_req", 32'(bus_if.mem_req), 32'd0);
    chk("reset_mem_we", 32'(bus_if.mem_we), 32'd0);
    chk("reset_mem_addr", bus_if.mem_addr, 32'd0);
    chk("reset_mem_wdata", bus_if.mem_wdata, 32'd0);
    chk("reset_hit_cnt", bus_if.hit_cnt, 32'd0);
    chk("reset_miss_cnt", bus_if.miss_cnt, 32'd0);
    bus_if.rd_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;

    do_access(1'b1, 4'b0, 32'h14, 32'd0);
    chk("cold_miss_cycles", 32'(miss_cycles - mc0), 32'd18);
    chk("cold_rd_data", last_hit_data, 32'h14);
    chk("cold_txn_count", 32'(txn_log.size()), 32'd8);
    for (int i = 0; i < txn_log.size(); i++) chk("cold_fill_addr", txn_log[i].addr, 32'(i * 4));
    chk("cold_hit_cnt", bus_if.hit_cnt, 32'd1);
    chk("cold_miss_cnt", bus_if.miss_cnt, 32'd1);

    do_access(1'b1, 4'b0, 32'h18, 32'd0);
    chk("hit_miss_cycles", 32'(miss_cycles - mc0), 32'd0);
    chk("hit_rd_data_18", last_hit_data, 32'h18);
    chk("hit_hit_cnt", bus_if.hit_cnt, 32'd2);

    do_access(1'b0, 4'b0010, 32'h14, 32'hAABBCCDD);
    chk("store_miss_cycles", 32'(miss_cycles - mc0), 32'd0);
    do_access(1'b1, 4'b0, 32'h14, 32'd0);
    chk("store_readback", last_hit_data, 32'h0000CC14);

    do_access(1'b1, 4'b0, 32'h94, 32'd0);
    chk("dirty_miss_cycles", 32'(miss_cycles - mc0), 32'd34);
    chk("dirty_txn_count", 32'(txn_log.size()), 32'd16);
    for (int i = 0; i < 8; i++) begin
      chk("dirty_wb_we", 32'(txn_log[i].we), 32'd1);
      chk("dirty_wb_addr", txn_log[i].addr, 32'(i * 4));
      chk("dirty_fill_addr", txn_log[i + 8].addr, 32'(32'h80 + i * 4));
    end
    chk("dirty_wb_data_14", txn_log[5].data, 32'h0000CC14);
    chk("dirty_wb_data_00", txn_log[0].data, 32'h0);
    chk("dirty_rd_data", last_hit_data, 32'h94);

    start_access(1'b1, 4'b0, 32'h14, 32'd0, h0);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (fill_acks == 3) break;
    end
    chk("fill3_reached", 32'(fill_acks), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("midfill_mem_req", 32'(bus_if.mem_req), 32'd0);
    chk("midfill_hit_cnt", bus_if.hit_cnt, 32'd0);
    chk("midfill_miss_cnt", bus_if.miss_cnt, 32'd0);
    chk("midfill_miss", 32'(bus_if.miss), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    wait_hit(h0);
    chk("refill_txn_count", 32'(txn_log.size()), 32'd8);
    for (int i = 0; i < txn_log.size(); i++) chk("refill_addr", txn_log[i].addr, 32'(i * 4));
    chk("refill_rd_data", last_hit_data, 32'h0000CC14);
    chk("refill_hit_cnt", bus_if.hit_cnt, 32'd1);
    chk("refill_miss_cnt", bus_if.miss_cnt, 32'd1);

    lat_mode = 1;
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      logic [3:0]  be;
      int          kind;
      a = {25'($urandom_range(3, 0)), 2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)),
           2'($urandom_range(3, 0))};
      kind = int'($urandom_range(2, 0));
      be = (kind == 0) ? 4'b0 : 4'($urandom_range(15, 1));
      do_access(kind != 1, be, a, $urandom());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
